// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel magnitude pipeline.
// Mode encodings and default datapath widths.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_L1  = 2'b00,
        MODE_GX  = 2'b01,
        MODE_GY  = 2'b10,
        MODE_L2A = 2'b11
    } sobel_mode_e;

    localparam int SOBEL_IN_W   = 15;
    localparam int SOBEL_OUT_W  = 12;
    localparam int SOBEL_SHIFT  = 2;
    localparam int SOBEL_THRESH = 60;
    localparam int SOBEL_CNT_W  = 20;

endpackage

// File: rtl/sobel_frame_stats.sv
// Per-frame edge statistics: counts nonzero edge pixels and tracks the peak.
// Ports: iCLK, iRST (async low), iEdge/iDVAL/iFVAL (output-aligned),
//        oEdgeCount/oPeak (last frame), oStatsVld (update pulse).
module sobel_frame_stats
    import sobel_pkg::*;
#(
    parameter int OUT_W = SOBEL_OUT_W,
    parameter int CNT_W = SOBEL_CNT_W
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [OUT_W-1:0] iEdge,
    input  logic             iDVAL,
    input  logic             iFVAL,
    output logic [CNT_W-1:0] oEdgeCount,
    output logic [OUT_W-1:0] oPeak,
    output logic             oStatsVld
);

    logic             fval_d;
    logic             end_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OUT_W-1:0] peak_q;
    logic [CNT_W-1:0] cnt_base;
    logic [OUT_W-1:0] peak_base;
    logic [CNT_W-1:0] cnt_n;
    logic [OUT_W-1:0] peak_n;

    // On the clear cycle accumulation starts from zero, so a pixel of the
    // next frame landing on that cycle is still counted.
    always_comb begin
        cnt_base  = end_q ? '0 : cnt_q;
        peak_base = end_q ? '0 : peak_q;
        cnt_n     = cnt_base;
        peak_n    = peak_base;
        if (iDVAL && iFVAL) begin
            if (iEdge != '0 && cnt_base != '1) begin
                cnt_n = cnt_base + CNT_W'(1);
            end
            if (iEdge > peak_base) begin
                peak_n = iEdge;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fval_d     <= 1'b0;
            end_q      <= 1'b0;
            cnt_q      <= '0;
            peak_q     <= '0;
            oEdgeCount <= '0;
            oPeak      <= '0;
            oStatsVld  <= 1'b0;
        end else begin
            fval_d    <= iFVAL;
            end_q     <= fval_d & ~iFVAL;
            cnt_q     <= cnt_n;
            peak_q    <= peak_n;
            oStatsVld <= end_q;
            if (end_q) begin
                oEdgeCount <= cnt_q;
                oPeak      <= peak_q;
            end
        end
    end

endmodule

// File: rtl/sobel_mag_pipe.sv
// Two-stage Sobel edge magnitude: abs/combine, then shift/saturate/threshold.
// Ports: iCLK, iRST (async low), iSobelX/iSobelY/iDVAL/iFVAL/iMode/iThresh in;
//        oEdge/oDVAL pixel out, oEdgeCount/oPeak/oStatsVld frame stats out.
module sobel_mag_pipe
    import sobel_pkg::*;
#(
    parameter int IN_W           = SOBEL_IN_W,
    parameter int OUT_W          = SOBEL_OUT_W,
    parameter int SHIFT          = SOBEL_SHIFT,
    parameter int DEFAULT_THRESH = SOBEL_THRESH,
    parameter int CNT_W          = SOBEL_CNT_W
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic signed [IN_W-1:0] iSobelX,
    input  logic signed [IN_W-1:0] iSobelY,
    input  logic                   iDVAL,
    input  logic                   iFVAL,
    input  logic [1:0]             iMode,
    input  logic [OUT_W-1:0]       iThresh,
    output logic [OUT_W-1:0]       oEdge,
    output logic                   oDVAL,
    output logic [CNT_W-1:0]       oEdgeCount,
    output logic [OUT_W-1:0]       oPeak,
    output logic                   oStatsVld
);

    localparam int RAW_W = IN_W + 1;
    localparam logic [RAW_W-1:0] SAT_MAX = RAW_W'((1 << OUT_W) - 1);

    sobel_mode_e      mode_q;
    sobel_mode_e      mode_eff;
    logic [OUT_W-1:0] thresh_q;
    logic             fval1;
    logic             fval_p;
    logic             dval1;
    logic             frame_start;

    logic [IN_W-1:0]  sx, sy;
    logic [IN_W-1:0]  abs_x, abs_y;
    logic [IN_W-1:0]  mx, mn;
    logic [RAW_W-1:0] raw_d, raw_q;
    logic [RAW_W-1:0] scaled;
    logic [OUT_W-1:0] sat;
    logic [OUT_W-1:0] edge_d;

    // fval1 doubles as the previous iFVAL sample for frame-start detection.
    assign frame_start = iFVAL & ~fval1;
    assign mode_eff    = frame_start ? sobel_mode_e'(iMode) : mode_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            mode_q   <= MODE_L1;
            thresh_q <= OUT_W'(DEFAULT_THRESH);
        end else if (frame_start) begin
            mode_q   <= sobel_mode_e'(iMode);
            thresh_q <= iThresh;
        end
    end

    // Two's-complement negate in IN_W bits; the most negative input maps
    // to 2^(IN_W-1), which is representable as unsigned.
    assign sx    = iSobelX;
    assign sy    = iSobelY;
    assign abs_x = sx[IN_W-1] ? (~sx + IN_W'(1)) : sx;
    assign abs_y = sy[IN_W-1] ? (~sy + IN_W'(1)) : sy;
    assign mx    = (abs_x > abs_y) ? abs_x : abs_y;
    assign mn    = (abs_x > abs_y) ? abs_y : abs_x;

    always_comb begin
        raw_d = '0;
        unique case (mode_eff)
            MODE_L1:  raw_d = {1'b0, abs_x} + {1'b0, abs_y};
            MODE_GX:  raw_d = {1'b0, abs_x};
            MODE_GY:  raw_d = {1'b0, abs_y};
            MODE_L2A: raw_d = {1'b0, mx} + RAW_W'(mn >> 2) + RAW_W'(mn >> 3);
            default:  raw_d = '0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            raw_q <= '0;
            dval1 <= 1'b0;
            fval1 <= 1'b0;
        end else begin
            dval1 <= iDVAL;
            fval1 <= iFVAL;
            if (iDVAL) begin
                raw_q <= raw_d;
            end
        end
    end

    assign scaled = raw_q >> SHIFT;
    assign sat    = (scaled > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : scaled[OUT_W-1:0];
    assign edge_d = (sat < thresh_q) ? '0 : sat;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oEdge  <= '0;
            oDVAL  <= 1'b0;
            fval_p <= 1'b0;
        end else begin
            oDVAL  <= dval1;
            fval_p <= fval1;
            if (dval1) begin
                oEdge <= edge_d;
            end
        end
    end

    sobel_frame_stats #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_stats (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iEdge      (oEdge),
        .iDVAL      (oDVAL),
        .iFVAL      (fval_p),
        .oEdgeCount (oEdgeCount),
        .oPeak      (oPeak),
        .oStatsVld  (oStatsVld)
    );

endmodule

// File: tb/tb_sobel_mag_pipe.sv
// Self-checking bench for sobel_mag_pipe: directed cases plus random frames
// compared against a per-pixel / per-frame arithmetic reference model.
module tb_sobel_mag_pipe;

    localparam int IN_W  = 15;
    localparam int OUT_W = 12;
    localparam int CNT_W = 20;

    logic                   iCLK = 1'b0;
    logic                   iRST = 1'b0;
    logic signed [IN_W-1:0] iSobelX = '0;
    logic signed [IN_W-1:0] iSobelY = '0;
    logic                   iDVAL = 1'b0;
    logic                   iFVAL = 1'b0;
    logic [1:0]             iMode = 2'b00;
    logic [OUT_W-1:0]       iThresh = 12'd60;
    logic [OUT_W-1:0]       oEdge;
    logic                   oDVAL;
    logic [CNT_W-1:0]       oEdgeCount;
    logic [OUT_W-1:0]       oPeak;
    logic                   oStatsVld;

    sobel_mag_pipe #(
        .IN_W           (IN_W),
        .OUT_W          (OUT_W),
        .SHIFT          (2),
        .DEFAULT_THRESH (60),
        .CNT_W          (CNT_W)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSobelX    (iSobelX),
        .iSobelY    (iSobelY),
        .iDVAL      (iDVAL),
        .iFVAL      (iFVAL),
        .iMode      (iMode),
        .iThresh    (iThresh),
        .oEdge      (oEdge),
        .oDVAL      (oDVAL),
        .oEdgeCount (oEdgeCount),
        .oPeak      (oPeak),
        .oStatsVld  (oStatsVld)
    );

    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_mode, m_thr;
    bit m_prev;
    bit p_v, p_cnt;
    int p_mag;
    bit e_dval, e_pulse;
    int e_edge;
    int acc_cnt, acc_peak, snap_cnt, snap_peak, out_cnt, out_peak, cd;

    task automatic chk(string tag, logic [31:0] got, int exp);
        total++;
        assert (got === 32'(exp)) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int mag(int gx, int gy, int md);
        int ax, ay, hi, lo, raw;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        hi = (ax > ay) ? ax : ay;
        lo = (ax > ay) ? ay : ax;
        case (md)
            0:       raw = ax + ay;
            1:       raw = ax;
            2:       raw = ay;
            default: raw = hi + lo / 4 + lo / 8;
        endcase
        raw = raw / 4;
        if (raw > 4095) raw = 4095;
        return raw;
    endfunction

    function automatic int rnd_g();
        int r;
        r = int'($urandom_range(0, 32767)) - 16384;
        if ($urandom_range(0, 1) == 1) r = r / 20;
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_thr = 60; m_prev = 0;
        p_v = 0; p_cnt = 0; p_mag = 0;
        e_dval = 0; e_pulse = 0; e_edge = 0;
        acc_cnt = 0; acc_peak = 0; snap_cnt = 0; snap_peak = 0;
        out_cnt = 0; out_peak = 0; cd = 0;
    endtask

    // One clock: drive at negedge, update model at posedge, check after.
    task automatic step(bit dv, bit fv, int gx, int gy);
        @(negedge iCLK);
        iDVAL = dv;
        iFVAL = fv;
        iSobelX = IN_W'(gx);
        iSobelY = IN_W'(gy);
        @(posedge iCLK);
        e_dval = p_v;
        if (p_v) begin
            e_edge = (p_mag < m_thr) ? 0 : p_mag;
            if (p_cnt) begin
                if (e_edge != 0) acc_cnt++;
                if (e_edge > acc_peak) acc_peak = e_edge;
            end
        end
        e_pulse = 0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                e_pulse = 1;
                out_cnt = snap_cnt;
                out_peak = snap_peak;
            end
        end
        if (!fv && m_prev) begin
            cd = 3;
            snap_cnt = acc_cnt;
            snap_peak = acc_peak;
            acc_cnt = 0;
            acc_peak = 0;
        end
        if (fv && !m_prev) begin
            m_mode = int'(iMode);
            m_thr = int'(iThresh);
        end
        m_prev = fv;
        p_v = dv;
        p_cnt = dv && fv;
        if (dv) p_mag = mag(gx, gy, m_mode);
        #1;
        chk("dval", oDVAL, e_dval);
        chk("edge", oEdge, e_edge);
        chk("svld", oStatsVld, e_pulse);
        chk("count", oEdgeCount, out_cnt);
        chk("peak", oPeak, out_peak);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Called right after the last in-frame step.
    task automatic end_frame(string tag, int c, int p);
        repeat (3) step(0, 0, 0, 0);
        chk({tag, "_pre"}, oStatsVld, 0);
        step(0, 0, 0, 0);
        chk({tag, "_vld"}, oStatsVld, 1);
        chk({tag, "_cnt"}, oEdgeCount, c);
        chk({tag, "_peak"}, oPeak, p);
        step(0, 0, 0, 0);
        chk({tag, "_one"}, oStatsVld, 0);
    endtask

    task automatic all_zero(string tag);
        chk({tag, "_edge"}, oEdge, 0);
        chk({tag, "_dval"}, oDVAL, 0);
        chk({tag, "_cnt"}, oEdgeCount, 0);
        chk({tag, "_peak"}, oPeak, 0);
        chk({tag, "_svld"}, oStatsVld, 0);
    endtask

    initial begin
        int vals[10];
        int len, gap;
        vals = '{0, 0, 80, 0, 300, 0, 120, 0, 0, 75};
        model_reset();

        #1;
        all_zero("reset");
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        idle(2);

        // mode 00: latency, L1, saturation, threshold boundary
        iMode = 2'd0; iThresh = 12'd60;
        step(1, 1, -400, 200);
        chk("lat_k", oDVAL, 0);
        step(1, 1, 16380, 16380);
        chk("lat_k1", oDVAL, 1);
        chk("l1_150", oEdge, 150);
        step(1, 1, 236, 0);
        chk("l1_sat", oEdge, 4095);
        step(1, 1, 240, 0);
        chk("thr_59", oEdge, 0);
        step(0, 1, 0, 0);
        chk("thr_60", oEdge, 60);
        idle(5);

        iMode = 2'd3;
        step(1, 1, 800, -400);
        step(0, 1, 0, 0);
        chk("l2a_237", oEdge, 237);
        idle(5);

        iMode = 2'd1;
        step(1, 1, -16384, 77);
        step(0, 1, 0, 0);
        chk("gx_sat", oEdge, 4095);
        idle(5);

        // mid-frame threshold/mode changes take effect next frame
        iMode = 2'd0; iThresh = 12'd60;
        step(1, 1, 384, 0);
        iThresh = 12'd100; iMode = 2'd2;
        step(1, 1, 384, 0);
        chk("thr_old_a", oEdge, 96);
        step(0, 1, 0, 0);
        chk("thr_old_b", oEdge, 96);
        idle(5);
        step(1, 1, 384, 0);
        step(1, 1, 0, 400);
        chk("thr_new", oEdge, 0);
        step(0, 1, 0, 0);
        chk("mode_new", oEdge, 100);
        idle(5);

        // 10-pixel stats frame then an empty frame
        iMode = 2'd1; iThresh = 12'd60;
        for (int i = 0; i < 10; i++) step(1, 1, 4 * vals[i], 0);
        end_frame("stats10", 4, 300);
        repeat (3) step(0, 1, 0, 0);
        end_frame("empty", 0, 0);

        // back-to-back frames with a one-cycle gap
        step(1, 1, 400, 0);
        step(1, 1, 800, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 240, 0);
        step(1, 1, 1000, 0);
        step(1, 1, 0, 0);
        chk("b2b_vld", oStatsVld, 1);
        chk("b2b_cnt", oEdgeCount, 2);
        chk("b2b_peak", oPeak, 200);
        step(1, 1, 160, 0);
        end_frame("b2b_f2", 2, 250);
        idle(2);

        // asynchronous reset in the middle of a frame
        iMode = 2'd0; iThresh = 12'd100;
        step(1, 1, 400, 0);
        step(1, 1, 800, 0);
        @(negedge iCLK);
        #2;
        iRST = 1'b0; iDVAL = 1'b0; iFVAL = 1'b0;
        #1;
        all_zero("midrst");
        model_reset();
        @(negedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        step(1, 0, 236, 0);
        step(1, 0, 280, 0);
        chk("rst_def59", oEdge, 0);
        step(0, 0, 0, 0);
        chk("rst_def70", oEdge, 70);
        iThresh = 12'd60;
        step(1, 1, 400, 0);
        step(1, 1, 400, 0);
        end_frame("rst_frame", 2, 100);

        // random frames against the reference model
        for (int f = 0; f < 8; f++) begin
            iMode = 2'($urandom_range(0, 3));
            iThresh = 12'($urandom_range(0, 400));
            len = int'($urandom_range(5, 30));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    iMode = 2'($urandom_range(0, 3));
                    iThresh = 12'($urandom_range(0, 400));
                end
                step($urandom_range(0, 3) != 0, 1, rnd_g(), rnd_g());
            end
            gap = int'($urandom_range(1, 5));
            for (int i = 0; i < gap; i++) begin
                step($urandom_range(0, 1) == 1, 0, rnd_g(), rnd_g());
            end
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
